image_loader: RTL and testbench
===============================

# image_loader

Front-end writer for the MNIST inference datapath. Accepts a frame of 784 8-bit grayscale pixels over a valid/ready stream and converts each pixel to the datapath's Q3.13 fixed-point format. Writes the converted pixels into the input region of the input/output RAM and starts the classifier through its Compute/R handshake. When the classifier reports completion, the block reduces the 10 output probabilities to a single predicted digit.

## Interface
Parameters:
- N_PIXELS, 784, pixels per frame.
- N_CLASSES, 10, number of probability outputs scanned.
- PIX_W, 8, input pixel width.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high.
- Pix_Valid  in  1  pixel stream valid.
- Pix_Data  in  PIX_W  unsigned grayscale pixel, 0 = black, 255 = white.
- Pix_Last  in  1  marks final pixel of frame; qualified by Pix_Valid.
- Pix_Ready  out  1  block accepts a pixel this cycle.
- Wr_En  out  1  input-RAM write strobe.
- Wr_Address  out  10  input-RAM address, equal to INPUT + pixel index.
- Wr_Data  out  16  converted pixel, Q3.13.
- Compute  out  1  classifier start request.
- R  in  1  classifier result-ready.
- Probability  in  16 x N_CLASSES  classifier outputs, unsigned.
- Digit  out  4  predicted class.
- Digit_Valid  out  1  Digit is valid.
- Busy  out  1  high in any state except LOAD with index 0.
- Error  out  1  sticky framing error for the last frame.

## Operation
- States are LOAD, DRAIN, FIRE, SETTLE, SCAN and DONE.
- **LOAD:**
  - Pix_Ready = 1.
  - A transfer occurs when Pix_Valid && Pix_Ready. The accepted pixel p, at index i, produces Wr_Data = {3'b000, p, p[7:3]}, which equals p·32 + p>>3. This maps 0 to 0x0000 and 255 to 0x1FFF.
  - Wr_Address = INPUT + i.
  - After each transfer, i increments.
  - The first transfer of a frame clears Digit_Valid and Error.
- **Framing:**
  - If Pix_Last arrives with i = N_PIXELS−1, the frame is good. The block goes to FIRE and i resets to 0.
  - If Pix_Last arrives with i < N_PIXELS−1, the frame is short. Error is set, the frame is discarded, i resets to 0, and the block stays in LOAD.
  - If i = N_PIXELS−1 is transferred without Pix_Last, the frame is long. Error is set, and the block goes to DRAIN.
  - The pixel that completes a short or long frame is still written to RAM. The frame is discarded afterwards, and Compute is never asserted for it.
- **DRAIN:** Pix_Ready = 1 and Wr_En = 0. Pixels are discarded until a transfer with Pix_Last, then the block returns to LOAD with i = 0.
- **FIRE:**
  - Pix_Ready = 0.
  - Compute = 1 and is held until R is sampled high.
  - On the cycle R is sampled high, the block goes to SETTLE, and Compute is 0 from the next cycle.
- **SETTLE:** one cycle. The classifier's Probability registers load on the R cycle, so this cycle lets them become stable.
- **SCAN:**
  - Takes N_CLASSES cycles, examining index k = 0..9 with one compare per cycle.
  - best_val and best_idx are initialised from k = 0.
  - The best entry is replaced only when Probability[k] > best_val, unsigned and strictly greater. Ties therefore resolve to the lowest index.
- **DONE:**
  - Digit = best_idx and Digit_Valid = 1.
  - Moves to LOAD the next cycle.
  - Digit and Digit_Valid hold until the first transfer of the next frame.
- **Reset:**
  - Reset is allowed in any state, including mid-frame and mid-FIRE. It forces LOAD, i = 0 and clears all outputs.
  - The partially written RAM contents are not cleared.

## Timing
- Reset values:
  - Pix_Ready = 1.
  - Wr_En = 0, Wr_Address = 0, Wr_Data = 0.
  - Compute = 0.
  - Digit = 0, Digit_Valid = 0.
  - Busy = 0.
  - Error = 0.
- The write path is registered. A transfer at cycle t gives Wr_En, Wr_Address and Wr_Data valid at t+1 for exactly one cycle.
- Throughput is 1 pixel per cycle with no bubbles. A full frame loads in 784 cycles of continuous Pix_Valid.
- Compute rises the cycle after the Pix_Last transfer. It falls the cycle after R is sampled high.
- Digit_Valid rises 1 (SETTLE) + 10 (SCAN) + 1 = 12 cycles after the R-high cycle.
- If R is already high on entry to FIRE, the handshake completes in 1 cycle.
- Pix_Ready is 0 from FIRE through DONE. Upstream must hold its data.

## Structure
- N_PIXELS, N_CLASSES and the Q-format fraction width (13) go in CONSTANTS.sv.
- The base address INPUT comes from BRAM_ADDRS.
- The state enum is typedef'd in the same package.
- One sub-module, pixel_to_q13, holds the combinational pixel conversion.
- The argmax scan stays inline.

## Test plan
- Reset, then stream 784 pixels with p = i mod 256 and Pix_Last on the final pixel. Required:
  - 784 writes.
  - Address INPUT+0 gets 0x0000.
  - Address INPUT+255 gets 0x1FFF.
  - Address INPUT+128 gets 0x1010.
  - Compute rises the cycle after the last transfer.
- Classifier model asserts R 50 cycles after Compute with Probability = {0x0100, 0x0200, 0x1F00, 0x0300, 0, 0, 0, 0, 0, 0x1F00}. Required: Compute held for 50 cycles, then Digit = 2 (tie resolves to the lower index) and Digit_Valid exactly 12 cycles after R.
- Pix_Last on pixel index 99. Required: Error = 1, no Compute, Busy = 0. A following good frame clears Error on its first transfer.
- 800 pixels with Pix_Last on the 800th. Required: Error = 1 after pixel 784, Wr_En stays low for pixels 785–800, no Compute, and the block is back in LOAD after the Last transfer.
- Randomly deasserted Pix_Valid (50% duty). Required: writes remain contiguous by address, with Wr_Data correct for each.
- Reset asserted at pixel 400 and again during FIRE. Required: all outputs return to their reset values the next cycle, and a new full frame then classifies normally.

Source files
------------

// File: rtl/image_loader_pkg.sv
// Shared constants, RAM map and state encoding for the MNIST front-end loader.
package image_loader_pkg;
  localparam int N_PIXELS_DEF  = 784;
  localparam int N_CLASSES_DEF = 10;
  localparam int PIX_W_DEF     = 8;
  localparam int Q_FRAC        = 13;
  localparam int ADDR_W        = 10;

  // Base of the input region in the shared input/output RAM.
  localparam logic [ADDR_W-1:0] INPUT = 10'd32;

  typedef enum logic [2:0] {LOAD, DRAIN, FIRE, SETTLE, SCAN, DONE} state_e;
endpackage

// File: rtl/image_loader_pixel_to_q13.sv
// Grayscale pixel to Q3.13: p*2^5 + p>>3, so full-scale white lands on 0x1FFF.
module pixel_to_q13
  import image_loader_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W-1:0] pix,
  output logic [15:0]      q
);
  localparam int SH = Q_FRAC - PIX_W;

  // Replicating the top bits into the vacated LSBs gives an exact 0..1 span.
  assign q = 16'({pix, pix[PIX_W-1 -: SH]});
endmodule

// File: rtl/image_loader.sv
// Streams a pixel frame into the input RAM, kicks the classifier, and argmaxes its outputs.
module image_loader
  import image_loader_pkg::*;
#(
  parameter int N_PIXELS  = N_PIXELS_DEF,
  parameter int N_CLASSES = N_CLASSES_DEF,
  parameter int PIX_W     = PIX_W_DEF
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Pix_Valid,
  input  logic [PIX_W-1:0]            Pix_Data,
  input  logic                        Pix_Last,
  output logic                        Pix_Ready,
  output logic                        Wr_En,
  output logic [ADDR_W-1:0]           Wr_Address,
  output logic [15:0]                 Wr_Data,
  output logic                        Compute,
  input  logic                        R,
  input  logic [N_CLASSES-1:0][15:0]  Probability,
  output logic [3:0]                  Digit,
  output logic                        Digit_Valid,
  output logic                        Busy,
  output logic                        Error
);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIXELS - 1);
  localparam logic [3:0]        LAST_CLS = 4'(N_CLASSES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [3:0]        k_q, k_d;
  logic [15:0]       best_val_q, best_val_d;
  logic [3:0]        best_idx_q, best_idx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [3:0]        digit_q, digit_d;
  logic              digit_valid_q, digit_valid_d;
  logic              error_q, error_d;
  logic [15:0]       pix_q13;
  logic              xfer;
  logic              take;

  pixel_to_q13 #(.PIX_W(PIX_W)) u_conv (.pix(Pix_Data), .q(pix_q13));

  assign Pix_Ready   = (state_q == LOAD) || (state_q == DRAIN);
  assign xfer        = Pix_Valid && Pix_Ready;
  assign Compute     = (state_q == FIRE);
  assign Busy        = !((state_q == LOAD) && (idx_q == '0));
  assign Wr_En       = wr_en_q;
  assign Wr_Address  = wr_addr_q;
  assign Wr_Data     = wr_data_q;
  assign Digit       = digit_q;
  assign Digit_Valid = digit_valid_q;
  assign Error       = error_q;

  // Strict compare keeps the lowest index on ties; k=0 seeds the running best.
  assign take = (k_q == '0) || (Probability[k_q] > best_val_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    k_d           = k_q;
    best_val_d    = best_val_q;
    best_idx_d    = best_idx_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    digit_d       = digit_q;
    digit_valid_d = digit_valid_q;
    error_d       = error_q;
    case (state_q)
      LOAD: if (xfer) begin
        wr_en_d   = 1'b1;
        wr_addr_d = INPUT + idx_q;
        wr_data_d = pix_q13;
        idx_d     = idx_q + 1'b1;
        if (idx_q == '0) begin
          digit_valid_d = 1'b0;
          error_d       = 1'b0;
        end
        if (Pix_Last) begin
          idx_d = '0;
          if (idx_q == LAST_PIX) state_d = FIRE;
          else                   error_d = 1'b1;
        end else if (idx_q == LAST_PIX) begin
          idx_d   = '0;
          error_d = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN:  if (xfer && Pix_Last) state_d = LOAD;
      FIRE:   if (R) state_d = SETTLE;
      SETTLE: begin
        k_d     = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (take) begin
          best_val_d = Probability[k_q];
          best_idx_d = k_q;
        end
        k_d = k_q + 1'b1;
        if (k_q == LAST_CLS) begin
          digit_d       = take ? k_q : best_idx_q;
          digit_valid_d = 1'b1;
          state_d       = DONE;
        end
      end
      DONE:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= LOAD;
      idx_q         <= '0;
      k_q           <= '0;
      best_val_q    <= '0;
      best_idx_q    <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      k_q           <= k_d;
      best_val_q    <= best_val_d;
      best_idx_q    <= best_idx_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      error_q       <= error_d;
    end
  end
endmodule

// File: tb/tb_image_loader.sv
// Random-frame bench for image_loader with a frame/argmax reference model.
module tb_image_loader;
  import image_loader_pkg::*;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Pix_Valid = 1'b0;
  logic [7:0]       Pix_Data = '0;
  logic             Pix_Last = 1'b0;
  logic             R = 1'b0;
  logic [9:0][15:0] Probability = '0;
  logic             Pix_Ready, Wr_En, Compute, Digit_Valid, Busy, Error;
  logic [9:0]       Wr_Address;
  logic [15:0]      Wr_Data;
  logic [3:0]       Digit;

  image_loader dut (
    .Clk(Clk), .Reset(Reset), .Pix_Valid(Pix_Valid), .Pix_Data(Pix_Data),
    .Pix_Last(Pix_Last), .Pix_Ready(Pix_Ready), .Wr_En(Wr_En),
    .Wr_Address(Wr_Address), .Wr_Data(Wr_Data), .Compute(Compute), .R(R),
    .Probability(Probability), .Digit(Digit), .Digit_Valid(Digit_Valid),
    .Busy(Busy), .Error(Error)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int wr_a[$];
  int wr_d[$];
  int pix[1024];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk)
    if (Wr_En === 1'b1) begin
      wr_a.push_back(int'(Wr_Address));
      wr_d.push_back(int'(Wr_Data));
    end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  function automatic int q13(input int p);
    return p * 32 + p / 8;
  endfunction

  // Streams n pixels; Last flagged at index last_at (-1 = never).
  task automatic send_frame(input int n, input int last_at, input bit rnd_pix, input bit bubbles);
    int j = 0;
    int guard = 0;
    bit ok;
    for (int x = 0; x < n; x++) pix[x] = rnd_pix ? int'($urandom_range(0, 255)) : x % 256;
    wr_a.delete();
    wr_d.delete();
    while (j < n && guard < 8 * n + 100) begin
      Pix_Valid = bubbles ? ($urandom_range(0, 1) == 1) : 1'b1;
      Pix_Data  = 8'(pix[j]);
      Pix_Last  = (j == last_at);
      ok = Pix_Valid && Pix_Ready;
      cyc();
      guard++;
      if (ok) begin
        if (j == 0) begin
          chk("first_clr_err", Error, 0);
          chk("first_clr_dv", Digit_Valid, 0);
        end
        if (j == N_PIXELS_DEF - 1 && last_at != j) chk("long_err", Error, 1);
        j++;
      end
    end
    Pix_Valid = 1'b0;
    Pix_Last  = 1'b0;
    if (j < n) chk("frame_timeout", j, n);
  endtask

  task automatic check_writes(input int nexp);
    chk("wr_count", wr_a.size(), nexp);
    for (int i = 0; i < nexp && i < wr_a.size(); i++) begin
      chk("wr_addr", wr_a[i], int'(INPUT) + i);
      chk("wr_data", wr_d[i], q13(pix[i]));
    end
  endtask

  task automatic classify(input int delay, input logic [9:0][15:0] p);
    int best = 0;
    for (int k = 1; k < 10; k++) if (p[k] > p[best]) best = k;
    chk("compute_rise", Compute, 1);
    chk("ready_fire", Pix_Ready, 0);
    for (int c = 0; c < delay; c++) begin
      cyc();
      chk("compute_hold", Compute, 1);
    end
    R = 1'b1;
    Probability = p;
    cyc();
    R = 1'b0;
    chk("compute_fall", Compute, 0);
    for (int c = 1; c <= 11; c++) begin
      chk("dv_early", Digit_Valid, 0);
      cyc();
    end
    chk("dv_12", Digit_Valid, 1);
    chk("digit", Digit, best);
    chk("busy_done", Busy, 1);
    chk("ready_done", Pix_Ready, 0);
    cyc();
    chk("busy_idle", Busy, 0);
    chk("ready_idle", Pix_Ready, 1);
    chk("dv_hold", Digit_Valid, 1);
    chk("digit_hold", Digit, best);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Pix_Valid = 1'b0;
    Pix_Last = 1'b0;
    cyc();
    chk("rst_ready", Pix_Ready, 1);
    chk("rst_wren", Wr_En, 0);
    chk("rst_addr", Wr_Address, 0);
    chk("rst_data", Wr_Data, 0);
    chk("rst_compute", Compute, 0);
    chk("rst_digit", Digit, 0);
    chk("rst_dv", Digit_Valid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_error", Error, 0);
    Reset = 1'b0;
  endtask

  function automatic logic [9:0][15:0] rnd_probs();
    logic [9:0][15:0] p;
    for (int k = 0; k < 10; k++) p[k] = 16'($urandom_range(0, 7) << 8);
    return p;
  endfunction

  initial begin
    logic [9:0][15:0] spec_p;
    spec_p = '0;
    spec_p[0] = 16'h0100;
    spec_p[1] = 16'h0200;
    spec_p[2] = 16'h1F00;
    spec_p[3] = 16'h0300;
    spec_p[9] = 16'h1F00;

    cyc();
    do_reset();

    // Ramp frame and the reference classifier response.
    send_frame(784, 783, 0, 0);
    classify(50, spec_p);
    check_writes(784);
    if (wr_d.size() >= 784) begin
      chk("px0", wr_d[0], 32'h0000);
      chk("px255", wr_d[255], 32'h1FFF);
      chk("px128", wr_d[128], 32'h1010);
    end

    // Short frame, then a good bubbly frame clears Error.
    send_frame(100, 99, 1, 0);
    chk("short_err", Error, 1);
    chk("short_busy", Busy, 0);
    chk("short_compute", Compute, 0);
    cyc();
    chk("short_compute2", Compute, 0);
    check_writes(100);
    send_frame(784, 783, 1, 1);
    classify($urandom_range(0, 5), rnd_probs());
    check_writes(784);

    // Long frame drains without writes or Compute.
    send_frame(800, 799, 1, 0);
    chk("long_err_end", Error, 1);
    chk("long_compute", Compute, 0);
    chk("long_busy", Busy, 0);
    chk("long_ready", Pix_Ready, 1);
    cyc();
    chk("long_compute2", Compute, 0);
    check_writes(784);

    // Reset mid-frame and in FIRE, then classify normally.
    send_frame(400, -1, 1, 0);
    do_reset();
    check_writes(400);
    send_frame(784, 783, 1, 0);
    chk("fire_compute", Compute, 1);
    cyc();
    cyc();
    do_reset();
    for (int f = 0; f < 3; f++) begin
      send_frame(784, 783, 1, f != 0);
      classify(f == 0 ? 0 : int'($urandom_range(0, 8)), rnd_probs());
      check_writes(784);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
